// File: rtl/pe_nmr_pkg.sv
// Shared types and helpers for the N-modular-redundant systolic MAC tile.
// Fault modes are applied to replica outputs only, never to stored state.
package pe_nmr_pkg;

    typedef enum logic [1:0] {
        FI_NONE = 2'b00,
        FI_SA0  = 2'b01,
        FI_SA1  = 2'b10,
        FI_FLIP = 2'b11
    } fi_mode_t;

    localparam int ERR_CNT_W      = 8;
    localparam int MISMATCH_CNT_W = 4;
    localparam int MAX_WORD_W     = 64;

    // Works on a wide word so any WORD_SIZE up to MAX_WORD_W can share it;
    // callers zero-extend in and keep the low bits out.
    function automatic logic [MAX_WORD_W-1:0] apply_fault(
        input fi_mode_t              mode,
        input logic [MAX_WORD_W-1:0] word
    );
        logic [MAX_WORD_W-1:0] result;
        result = word;
        case (mode)
            FI_SA0:  result = '0;
            FI_SA1:  result = '1;
            FI_FLIP: result = {word[MAX_WORD_W-1:1], ~word[0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/pe_nmr_mac_replica.sv
// One unprotected MAC lane: stationary weight, wrapping accumulator and the
// registered east/south outputs that the redundancy voter compares.
module mac_replica #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op2_select,
    input  logic                 out_select,
    input  logic                 stat_bit,
    input  logic [WORD_SIZE-1:0] left,
    input  logic [WORD_SIZE-1:0] top,
    output logic [WORD_SIZE-1:0] right,
    output logic [WORD_SIZE-1:0] bottom
);

    logic [WORD_SIZE-1:0] weight;
    logic [WORD_SIZE-1:0] acc;
    logic [WORD_SIZE-1:0] op2;
    logic [WORD_SIZE-1:0] prod;
    logic [WORD_SIZE-1:0] sum;

    assign op2  = op2_select ? top : weight;
    assign prod = left * op2;
    assign sum  = acc + prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            weight <= '0;
            acc    <= '0;
            right  <= '0;
            bottom <= '0;
        end else begin
            right <= left;
            if (stat_bit) begin
                weight <= top;
                bottom <= top;
            end else begin
                acc    <= sum;
                bottom <= out_select ? sum : top;
            end
        end
    end

endmodule

// File: rtl/pe_nmr.sv
// Redundant MAC tile: N replicas, tie-safe bitwise voter, persistent-fault
// retirement with a floor of two voters, and status for the BISR controller.
module pe_nmr
    import pe_nmr_pkg::*;
#(
    parameter int WORD_SIZE       = 16,
    parameter int NUM_REPLICAS    = 3,
    parameter int MISMATCH_THRESH = 4,
    parameter int ENABLE_FI       = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fsm_op2_select_in,
    input  logic                      fsm_out_select_in,
    input  logic                      stat_bit_in,
    input  logic [2*NUM_REPLICAS-1:0] fault_inject_bus,
    input  logic [WORD_SIZE-1:0]      left_in,
    input  logic [WORD_SIZE-1:0]      top_in,
    output logic [WORD_SIZE-1:0]      right_out,
    output logic [WORD_SIZE-1:0]      bottom_out,
    output logic [NUM_REPLICAS-1:0]   replica_active,
    output logic                      fault_detected,
    output logic                      uncorrectable,
    output logic [ERR_CNT_W-1:0]      error_count
);

    localparam logic [MISMATCH_CNT_W-1:0] THRESH_C = MISMATCH_CNT_W'(MISMATCH_THRESH);

    logic [WORD_SIZE-1:0]      right_r  [NUM_REPLICAS];
    logic [WORD_SIZE-1:0]      bottom_r [NUM_REPLICAS];
    logic [WORD_SIZE-1:0]      right_f  [NUM_REPLICAS];
    logic [WORD_SIZE-1:0]      bottom_f [NUM_REPLICAS];
    logic [MISMATCH_CNT_W-1:0] mm_cnt   [NUM_REPLICAS];
    logic [NUM_REPLICAS-1:0]   mismatch;
    logic [NUM_REPLICAS-1:0]   active_next;
    int                        num_active;

    for (genvar g = 0; g < NUM_REPLICAS; g++) begin : g_rep
        fi_mode_t mode;

        mac_replica #(.WORD_SIZE(WORD_SIZE)) u_mac (
            .clk        (clk),
            .rst        (rst),
            .op2_select (fsm_op2_select_in),
            .out_select (fsm_out_select_in),
            .stat_bit   (stat_bit_in),
            .left       (left_in),
            .top        (top_in),
            .right      (right_r[g]),
            .bottom     (bottom_r[g])
        );

        assign mode        = (ENABLE_FI != 0) ? fi_mode_t'(fault_inject_bus[2*g +: 2]) : FI_NONE;
        assign right_f[g]  = WORD_SIZE'(apply_fault(mode, MAX_WORD_W'(right_r[g])));
        assign bottom_f[g] = WORD_SIZE'(apply_fault(mode, MAX_WORD_W'(bottom_r[g])));
    end

    // Strict majority of active replicas per bit; an exact tie defers to the
    // lowest-indexed active replica so an even voter set stays deterministic.
    always_comb begin : voter
        int   ones_r;
        int   ones_b;
        logic tie_r;
        logic tie_b;
        num_active = 0;
        right_out  = '0;
        bottom_out = '0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            if (replica_active[i]) num_active = num_active + 1;
        end
        for (int b = 0; b < WORD_SIZE; b++) begin
            ones_r = 0;
            ones_b = 0;
            tie_r  = 1'b0;
            tie_b  = 1'b0;
            for (int i = NUM_REPLICAS - 1; i >= 0; i--) begin
                if (replica_active[i]) begin
                    ones_r = ones_r + int'(right_f[i][b]);
                    ones_b = ones_b + int'(bottom_f[i][b]);
                    tie_r  = right_f[i][b];
                    tie_b  = bottom_f[i][b];
                end
            end
            right_out[b]  = (2 * ones_r > num_active) ? 1'b1 :
                            (2 * ones_r == num_active) ? tie_r : 1'b0;
            bottom_out[b] = (2 * ones_b > num_active) ? 1'b1 :
                            (2 * ones_b == num_active) ? tie_b : 1'b0;
        end
    end

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            mismatch[i] = replica_active[i] &&
                          ((right_f[i] != right_out) || (bottom_f[i] != bottom_out));
        end
    end

    assign fault_detected = |mismatch;

    // Retire in ascending index order but never drop below two voters.
    always_comb begin : retire
        int remaining;
        remaining   = num_active;
        active_next = replica_active;
        for (int i = 0; i < NUM_REPLICAS; i++) begin
            if (replica_active[i] && (mm_cnt[i] == THRESH_C) && (remaining > 2)) begin
                active_next[i] = 1'b0;
                remaining      = remaining - 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            replica_active <= '1;
            uncorrectable  <= 1'b0;
            error_count    <= '0;
            for (int i = 0; i < NUM_REPLICAS; i++) mm_cnt[i] <= '0;
        end else begin
            replica_active <= active_next;
            if (fault_detected && (num_active == 2)) uncorrectable <= 1'b1;
            if (fault_detected && (error_count != '1)) begin
                error_count <= error_count + ERR_CNT_W'(1);
            end
            for (int i = 0; i < NUM_REPLICAS; i++) begin
                if (!replica_active[i] || !mismatch[i]) begin
                    mm_cnt[i] <= '0;
                end else if (mm_cnt[i] != THRESH_C) begin
                    mm_cnt[i] <= mm_cnt[i] + MISMATCH_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_nmr.sv
// Directed bench for pe_nmr: a behavioural tile model checked every cycle,
// plus hand-computed expectations along the fault and retirement scenarios.
module tb_pe_nmr;

    localparam int W      = 16;
    localparam int N      = 3;
    localparam int THRESH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           fsm_op2_select_in;
    logic           fsm_out_select_in;
    logic           stat_bit_in;
    logic [2*N-1:0] fault_inject_bus;
    logic [W-1:0]   left_in;
    logic [W-1:0]   top_in;
    logic [W-1:0]   right_out;
    logic [W-1:0]   bottom_out;
    logic [N-1:0]   replica_active;
    logic           fault_detected;
    logic           uncorrectable;
    logic [7:0]     error_count;

    always #5 clk = ~clk;

    pe_nmr #(
        .WORD_SIZE       (W),
        .NUM_REPLICAS    (N),
        .MISMATCH_THRESH (THRESH),
        .ENABLE_FI       (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fsm_op2_select_in (fsm_op2_select_in),
        .fsm_out_select_in (fsm_out_select_in),
        .stat_bit_in       (stat_bit_in),
        .fault_inject_bus  (fault_inject_bus),
        .left_in           (left_in),
        .top_in            (top_in),
        .right_out         (right_out),
        .bottom_out        (bottom_out),
        .replica_active    (replica_active),
        .fault_detected    (fault_detected),
        .uncorrectable     (uncorrectable),
        .error_count       (error_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every replica holds the same fault-free state, faults
    // only distort what each replica presents to the vote.
    logic [W-1:0] m_weight, m_acc, m_right, m_bottom;
    logic [N-1:0] m_active;
    int           m_cnt [N];
    bit           m_unc;
    int           m_err;
    bit           m_valid = 1'b0;

    function automatic logic [W-1:0] inj(input logic [1:0] mode, input logic [W-1:0] v);
        case (mode)
            2'b01:   return '0;
            2'b10:   return '1;
            2'b11:   return v ^ W'(1);
            default: return v;
        endcase
    endfunction

    task automatic model_eval(output logic [W-1:0] vr, output logic [W-1:0] vb,
                              output logic [N-1:0] mm);
        logic [W-1:0] fr [N];
        logic [W-1:0] fb [N];
        int a, first, cr, cb;
        a = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            fr[i] = inj(fault_inject_bus[2*i +: 2], m_right);
            fb[i] = inj(fault_inject_bus[2*i +: 2], m_bottom);
            if (m_active[i]) begin
                a++;
                if (first < 0) first = i;
            end
        end
        for (int b = 0; b < W; b++) begin
            cr = 0;
            cb = 0;
            for (int i = 0; i < N; i++) begin
                if (m_active[i]) begin
                    cr += int'(fr[i][b]);
                    cb += int'(fb[i][b]);
                end
            end
            vr[b] = (2 * cr > a) ? 1'b1 : (2 * cr == a) ? fr[first][b] : 1'b0;
            vb[b] = (2 * cb > a) ? 1'b1 : (2 * cb == a) ? fb[first][b] : 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            mm[i] = m_active[i] && ((fr[i] != vr) || (fb[i] != vb));
        end
    endtask

    always @(posedge clk) begin
        logic [W-1:0] vr, vb, op2;
        logic [N-1:0] mm, nxt;
        int           a;
        if (rst) begin
            m_weight = '0;
            m_acc    = '0;
            m_right  = '0;
            m_bottom = '0;
            m_active = '1;
            m_unc    = 1'b0;
            m_err    = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            model_eval(vr, vb, mm);
            a   = $countones(m_active);
            nxt = m_active;
            for (int i = 0; i < N; i++) begin
                if (m_active[i] && m_cnt[i] == THRESH && a > 2) begin
                    nxt[i] = 1'b0;
                    a--;
                end
            end
            if (mm != 0 && $countones(m_active) == 2) m_unc = 1'b1;
            if (mm != 0 && m_err < 255) m_err++;
            for (int i = 0; i < N; i++) begin
                if (m_active[i] && mm[i]) m_cnt[i] = (m_cnt[i] < THRESH) ? m_cnt[i] + 1 : THRESH;
                else m_cnt[i] = 0;
            end
            m_active = nxt;
            op2      = fsm_op2_select_in ? top_in : m_weight;
            m_right  = left_in;
            if (stat_bit_in) begin
                m_weight = top_in;
                m_bottom = top_in;
            end else begin
                m_acc    = W'(m_acc + W'(left_in * op2));
                m_bottom = fsm_out_select_in ? m_acc : top_in;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] vr, vb;
        logic [N-1:0] mm;
        if (m_valid) begin
            model_eval(vr, vb, mm);
            check("right_out", 32'(right_out), 32'(vr));
            check("bottom_out", 32'(bottom_out), 32'(vb));
            check("replica_active", 32'(replica_active), 32'(m_active));
            check("fault_detected", 32'(fault_detected), 32'(mm != 0));
            check("uncorrectable", 32'(uncorrectable), 32'(m_unc));
            check("error_count", 32'(error_count), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst               = 1'b1;
        fault_inject_bus  = '0;
        left_in           = '0;
        top_in            = '0;
        fsm_op2_select_in = 1'b0;
        fsm_out_select_in = 1'b0;
        stat_bit_in       = 1'b0;
        repeat (2) tick();
        check("lit_reset_bottom", 32'(bottom_out), 32'd0);
        check("lit_reset_active", 32'(replica_active), 32'h7);
        check("lit_reset_err", 32'(error_count), 32'd0);

        // Fault-free accumulate: 2*3 per edge
        rst = 1'b0; left_in = 16'd2; top_in = 16'd3;
        fsm_op2_select_in = 1'b1; fsm_out_select_in = 1'b1;
        tick();
        check("lit_mac1_bottom", 32'(bottom_out), 32'd6);
        check("lit_mac1_right", 32'(right_out), 32'd2);
        check("lit_mac1_fd", 32'(fault_detected), 32'd0);
        tick();
        check("lit_mac2_bottom", 32'(bottom_out), 32'd12);

        // One-cycle stuck-at-0 on replica 0 is outvoted
        fault_inject_bus = 6'b000001;
        #1;
        check("lit_trans_fd", 32'(fault_detected), 32'd1);
        check("lit_trans_bottom", 32'(bottom_out), 32'd12);
        tick();
        fault_inject_bus = '0;
        #1;
        check("lit_trans_after_bottom", 32'(bottom_out), 32'd18);
        check("lit_trans_err", 32'(error_count), 32'd1);
        check("lit_trans_active", 32'(replica_active), 32'h7);
        check("lit_trans_fd_clear", 32'(fault_detected), 32'd0);

        // Persistent stuck-at-1 on replica 1 for THRESH edges, then retirement
        fault_inject_bus = 6'b001000;
        repeat (THRESH) tick();
        fault_inject_bus = '0;
        check("lit_persist_err", 32'(error_count), 32'd5);
        check("lit_persist_still_active", 32'(replica_active), 32'h7);
        tick();
        check("lit_retire_active", 32'(replica_active), 32'h5);
        check("lit_retire_bottom", 32'(bottom_out), 32'd48);
        check("lit_retire_fd", 32'(fault_detected), 32'd0);

        // Two voters left: a flip on replica 2 cannot retire it and is uncorrectable
        fault_inject_bus = 6'b110000;
        #1;
        check("lit_floor_fd", 32'(fault_detected), 32'd1);
        check("lit_floor_right", 32'(right_out), 32'd2);
        repeat (10) tick();
        check("lit_floor_active", 32'(replica_active), 32'h5);
        check("lit_floor_unc", 32'(uncorrectable), 32'd1);
        check("lit_floor_err", 32'(error_count), 32'd15);
        check("lit_floor_bottom", 32'(bottom_out), 32'd108);
        repeat (245) tick();
        check("lit_err_saturate", 32'(error_count), 32'd255);

        // Reset mid-operation restores every replica
        rst = 1'b1;
        fault_inject_bus = '0;
        tick();
        check("lit_rst_bottom", 32'(bottom_out), 32'd0);
        check("lit_rst_right", 32'(right_out), 32'd0);
        check("lit_rst_active", 32'(replica_active), 32'h7);
        check("lit_rst_unc", 32'(uncorrectable), 32'd0);
        check("lit_rst_err", 32'(error_count), 32'd0);

        // Weight-stationary: load 5, then accumulate 4*5
        rst = 1'b0; stat_bit_in = 1'b1; top_in = 16'd5; left_in = 16'd4;
        fsm_op2_select_in = 1'b0; fsm_out_select_in = 1'b1;
        tick();
        check("lit_ws_load_bottom", 32'(bottom_out), 32'd5);
        stat_bit_in = 1'b0; top_in = 16'd0;
        tick();
        check("lit_ws_bottom1", 32'(bottom_out), 32'd20);
        tick();
        check("lit_ws_bottom2", 32'(bottom_out), 32'd40);
        fsm_out_select_in = 1'b0; top_in = 16'd7;
        tick();
        check("lit_pass_top", 32'(bottom_out), 32'd7);

        // Accumulator wrap: 0xFFFF + 1 -> 0
        rst = 1'b1;
        tick();
        rst = 1'b0; fsm_op2_select_in = 1'b1; fsm_out_select_in = 1'b1;
        left_in = 16'd1; top_in = 16'hFFFF;
        tick();
        check("lit_wrap_pre", 32'(bottom_out), 32'hFFFF);
        top_in = 16'd1;
        tick();
        check("lit_wrap", 32'(bottom_out), 32'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
